// File: rtl/register_bank_pkg.sv
// Shared register-file types and sizes; imported by decode, write-back and the bank itself.
package register_bank_pkg;

  localparam int RB_DATA_WIDTH = 32;
  localparam int RB_ADDR_WIDTH = 5;
  localparam int RB_DEPTH      = 32;

  typedef logic [RB_ADDR_WIDTH-1:0] rb_addr_t;
  typedef logic [RB_DATA_WIDTH-1:0] rb_data_t;

endpackage

// File: rtl/register_bank.sv
// 32 x 32-bit register bank: two combinational read ports, one synchronous write port.
// Register 0 is an ordinary register; reads have no write-through bypass.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Name is fixed: benches preload it by hierarchical reference.
  logic [DATA_WIDTH-1:0] bank [DEPTH];

  // Reset wins over a coincident write; writeReg/writeData are only looked at
  // when regWrite is high, so unknowns on them cannot disturb the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else if (regWrite) begin
      bank[writeReg] <= writeData;
    end
  end

  assign readData1 = bank[readReg1];
  assign readData2 = bank[readReg2];

endmodule

// File: tb/tb_register_bank.sv
// Directed plus randomized checks of register_bank against an array model of the register file.
module tb_register_bank;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] readData1;
  logic [31:0] readData2;

  register_bank dut (
    .clk       (clk),
    .rst       (rst),
    .regWrite  (regWrite),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected values are queued from the model, then popped against the ports.
  task automatic compare_reads(input string tag);
    logic [31:0] e1, e2;
    exp_q.push_back(model[readReg1]);
    exp_q.push_back(model[readReg2]);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    check({tag, ".rd1"}, readData1, e1);
    check({tag, ".rd2"}, readData2, e2);
  endtask

  task automatic model_edge(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (r) begin
      foreach (model[i]) model[i] = 32'd0;
    end else if (we) begin
      model[wa] = wd;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive after negedge, check old values before the edge, new values after it.
  task automatic step(input string tag, input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst = r; regWrite = we; writeReg = wa; writeData = wd;
    readReg1 = a1; readReg2 = a2;
    #1;
    compare_reads({tag, ".pre"});
    @(posedge clk);
    model_edge(r, we, wa, wd);
    #1;
    compare_reads({tag, ".post"});
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    readReg1 = a1; readReg2 = a2;
    #1;
    compare_reads(tag);
  endtask

  task automatic backdoor(input int idx, input logic [31:0] val);
    dut.bank[idx] <= val;
    model[idx] = val;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      readReg1 = 5'(a); readReg2 = 5'(31 - a);
      #1;
      check({tag, ".rd1"}, readData1, 32'd0);
      check({tag, ".rd2"}, readData2, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (model[i]) model[i] = 32'd0;
    rst = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset_state");

    // reset clears an earlier write
    step("write7", 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd31);
    step("reset_clear", 1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd31);
    check("reset_clear.r7", readData1, 32'd0);

    // backdoor preload after the last reset edge
    @(negedge clk);
    rst = 1'b0; regWrite = 1'b0;
    backdoor(16, 32'd16);
    backdoor(17, 32'd17);
    backdoor(31, 32'hA5A5_0031);
    backdoor(27, 32'h5A5A_0027);
    backdoor(23, 32'h1234_0023);
    backdoor(5,  32'h0000_1111);
    read_check("preload", 5'd16, 5'd17);
    check("preload.lit16", readData1, 32'd16);
    check("preload.lit17", readData2, 32'd17);
    step("preload_hold0", 1'b0, 1'b0, 'x, 'x, 5'd16, 5'd17);
    step("preload_hold1", 1'b0, 1'b0, 'x, 'x, 5'd16, 5'd17);

    // register 0 is writable
    step("write_r0", 1'b0, 1'b1, 5'd0, 32'd50, 5'd31, 5'd27);
    @(negedge clk);
    regWrite = 1'b0;
    read_check("after_r0", 5'd0, 5'd23);
    check("after_r0.lit50", readData1, 32'd50);

    // read during write returns old then new
    step("rdw", 1'b0, 1'b1, 5'd5, 32'h0000_2222, 5'd5, 5'd5);
    check("rdw.lit", readData2, 32'h0000_2222);

    // disabled write port leaves reg 9 alone
    step("wr9", 1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd0);
    for (int k = 0; k < 3; k++)
      step("wr_disabled", 1'b0, 1'b0, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd5);
    check("wr_disabled.lit", readData1, 32'h0BAD_F00D);

    // reset beats a coincident write
    step("set_r3", 1'b0, 1'b1, 5'd3, 32'd7, 5'd3, 5'd3);
    step("rst_vs_wr", 1'b1, 1'b1, 5'd3, 32'd99, 5'd3, 5'd9);
    check("rst_vs_wr.lit", readData1, 32'd0);
    @(negedge clk);
    rst = 1'b0; regWrite = 1'b0;
    check_all_zero("rst_vs_wr_all");

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 300; n++) begin
      logic r, we;
      r  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 3) != 0);
      step("rand", r, we, 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    rst = 1'b0; regWrite = 1'b0;
    for (int a = 0; a < 32; a++)
      read_check("final_sweep", 5'(a), 5'($urandom_range(0, 31)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Register bank for the single-cycle datapath: 32 general-purpose registers, each 32 bits wide. It has two independent asynchronous read ports, which feed the ALU operand paths, and one synchronous write port, which takes the write-back result. It sits between instruction decode (register addresses) and the ALU/write-back stage. Register 0 is an ordinary writable register and is not hardwired to zero.

## Interface
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, width of every register address; depth is 2**ADDR_WIDTH = 32.
- clk  input  1  clock; all state changes occur on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- regWrite  input  1  write enable for the write port.
- readReg1  input  ADDR_WIDTH  address for read port 1.
- readReg2  input  ADDR_WIDTH  address for read port 2.
- writeReg  input  ADDR_WIDTH  address for the write port.
- writeData  input  DATA_WIDTH  data for the write port.
- readData1  output  DATA_WIDTH  contents of bank[readReg1].
- readData2  output  DATA_WIDTH  contents of bank[readReg2].

## Operation
- Storage is an array named `bank` with 32 entries of DATA_WIDTH bits, indexed 0..31.
- The array name is fixed so that benches can preload it by hierarchical reference, for example binary-file load into `bank`.
- Read ports:
  - Purely combinational: readData1 = bank[readReg1] and readData2 = bank[readReg2].
  - The two ports are independent and may address the same register.
- Write port: on a rising clk edge with rst=0 and regWrite=1, bank[writeReg] <= writeData.
- All 32 addresses are writable, including address 0.
- regWrite=0: no register changes. writeReg and writeData are don't-care, and X values on them must not corrupt state.
- Reset: on a rising clk edge with rst=1, every entry of bank is cleared to 0. Reset takes priority over a simultaneous write.
- No X/Z handling: an unknown read address may drive X on the corresponding output.

## Timing
- Read latency is zero. An output follows any change of its address, or of the addressed register, within the same cycle.
- Write takes effect at the rising edge. Reads of writeReg return the new value starting immediately after that edge.
- Read-during-write, same address, same cycle: before the edge the read returns the old value. There is no write-through bypass.
- Reset behaviour:
  - Reset is synchronous; asserting rst between edges has no effect until the next rising edge.
  - After one reset edge, readData1 = readData2 = 0 for any address.
  - Reset asserted in the middle of a run discards all contents at that edge.
- Backdoor preload through `bank` is valid only after the last reset edge.

## Structure
- Shared package holds:
  - RB_DATA_WIDTH = 32, RB_ADDR_WIDTH = 5, RB_DEPTH = 32.
  - typedefs rb_addr_t (logic [4:0]) and rb_data_t (logic [31:0]), reused by the decode and write-back stages.
- Single module; no sub-module is warranted. The bank array, write process and two read muxes all live in register_bank.

## Test plan
- Reset clear: write 32'hDEADBEEF to reg 7, then assert rst for 1 edge -> readData1 (readReg1=7) = 0 and readData2 (readReg2=31) = 0.
- Preload read: backdoor-load bank[16]=32'd16 and bank[17]=32'd17 after reset, with regWrite=0 and readReg1=16, readReg2=17 -> readData1=16 and readData2=17 combinationally, and no register changes over 2 clocks.
- Write register 0:
  - Stimulus: regWrite=1, writeReg=0, writeData=32'd50, with readReg1=31 and readReg2=27 during the write cycle.
  - Then regWrite=0, readReg1=0, readReg2=23.
  - Required response: readData1 shows preloaded bank[31] and readData2 shows bank[27], both unchanged; after the edge readData1=50 and readData2=preloaded bank[23].
- Read-during-write: bank[5]=32'h1111, then write 32'h2222 to reg 5 with readReg1=readReg2=5 -> both outputs 32'h1111 before the edge and 32'h2222 after it.
- Write disabled: regWrite=0, writeReg=9, writeData=32'hFFFF_FFFF over 3 edges -> bank[9] keeps its prior value.
- Reset vs write priority: rst=1 and regWrite=1, writeReg=3, writeData=32'd99 on the same edge -> bank[3]=0.
